// File: rtl/ysyx_23060136_idu_issue_stage.sv
// Registered decode/issue stage with GPR file and per-register in-flight scoreboard.
// Optional same-cycle write-back bypass: define YSYX_23060136_WB_BYPASS_EN.
module ysyx_23060136_idu_issue_stage #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned NUM_GPR      = 32,
  parameter int unsigned MAX_INFLIGHT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic            in_pre_take,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic            out_pre_take,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic            out_wen,
  input  logic            WB_o_retire,
  input  logic [4:0]      WB_o_rd,
  input  logic            WB_o_RegWr,
  input  logic [XLEN-1:0] WB_o_rf_busW,
  output logic            stall_raw
);

  localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned AW = $clog2(NUM_GPR);
  localparam logic [CW:0]   CapLim = (CW + 1)'(MAX_INFLIGHT);
  localparam logic [CW-1:0] CntMax = CW'(MAX_INFLIGHT);

  logic [XLEN-1:0] gpr_q [NUM_GPR];
  logic [CW-1:0]   sb_q  [NUM_GPR];

  // Architectural register that exists and is not x0.
  function automatic logic idx_ok(input logic [4:0] r);
    return (r != 5'd0) && (32'(r) < NUM_GPR);
  endfunction

  logic [6:0] dec_op;
  logic [2:0] dec_f3;
  logic [4:0] dec_rd, dec_rs1, dec_rs2;
  logic       use_rs1, use_rs2, wen_class, dec_wen;

  assign dec_op  = in_inst[6:0];
  assign dec_rd  = in_inst[11:7];
  assign dec_f3  = in_inst[14:12];
  assign dec_rs1 = in_inst[19:15];
  assign dec_rs2 = in_inst[24:20];

  always_comb begin
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    wen_class = 1'b0;
    case (dec_op)
      7'b0110111, 7'b0010111, 7'b1101111: wen_class = 1'b1;
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0011011: begin
        use_rs1   = 1'b1;
        wen_class = 1'b1;
      end
      7'b0110011, 7'b0111011: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        wen_class = 1'b1;
      end
      7'b1100011, 7'b0100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b1110011: begin
        use_rs1   = (dec_f3 != 3'd0);
        wen_class = (dec_f3 != 3'd0);
      end
      default: ;
    endcase
  end

  assign dec_wen = wen_class && idx_ok(dec_rd);

  logic out_w_rs1, out_w_rs2, out_w_rd;
  assign out_w_rs1 = out_valid && out_wen && (out_rd == dec_rs1);
  assign out_w_rs2 = out_valid && out_wen && (out_rd == dec_rs2);
  assign out_w_rd  = out_valid && out_wen && (out_rd == dec_rd);

  logic [CW-1:0] sb_rs1, sb_rs2, sb_rd;
  assign sb_rs1 = sb_q[dec_rs1[AW-1:0]];
  assign sb_rs2 = sb_q[dec_rs2[AW-1:0]];
  assign sb_rd  = sb_q[dec_rd[AW-1:0]];

  logic byp_rs1, byp_rs2;
`ifdef YSYX_23060136_WB_BYPASS_EN
  // Last outstanding writer retires this cycle: take its value straight from the WB port.
  assign byp_rs1 = WB_o_retire && WB_o_RegWr && idx_ok(dec_rs1) && (WB_o_rd == dec_rs1) &&
                   (sb_rs1 == CW'(1)) && !out_w_rs1;
  assign byp_rs2 = WB_o_retire && WB_o_RegWr && idx_ok(dec_rs2) && (WB_o_rd == dec_rs2) &&
                   (sb_rs2 == CW'(1)) && !out_w_rs2;
`else
  assign byp_rs1 = 1'b0;
  assign byp_rs2 = 1'b0;
`endif

  logic          haz_rs1, haz_rs2, cap_stall, fire;
  logic [CW:0]   cap_sum;
  assign haz_rs1 = use_rs1 && idx_ok(dec_rs1) && ((sb_rs1 != '0) || out_w_rs1) && !byp_rs1;
  assign haz_rs2 = use_rs2 && idx_ok(dec_rs2) && ((sb_rs2 != '0) || out_w_rs2) && !byp_rs2;
  assign cap_sum = {1'b0, sb_rd} + {{CW{1'b0}}, out_w_rd};
  assign cap_stall = dec_wen && (cap_sum >= CapLim);

  assign in_ready  = rst && !flush && (!out_valid || out_ready) && !haz_rs1 && !haz_rs2 &&
                     !cap_stall;
  assign fire      = in_valid && in_ready;
  assign stall_raw = rst && in_valid && !in_ready && (haz_rs1 || haz_rs2 || cap_stall);

  logic [XLEN-1:0] rdata1, rdata2;
  always_comb begin
    rdata1 = idx_ok(dec_rs1) ? gpr_q[dec_rs1[AW-1:0]] : '0;
    rdata2 = idx_ok(dec_rs2) ? gpr_q[dec_rs2[AW-1:0]] : '0;
    if (byp_rs1) rdata1 = WB_o_rf_busW;
    if (byp_rs2) rdata2 = WB_o_rf_busW;
  end

  // Squashed out entries never reach the scoreboard.
  logic inc_en, dec_en, same_reg, inc_err, dec_err;
  assign inc_en   = out_valid && out_ready && out_wen && !flush;
  assign dec_en   = WB_o_retire && idx_ok(WB_o_rd);
  assign same_reg = inc_en && dec_en && (out_rd == WB_o_rd);
  assign inc_err  = inc_en && !same_reg && (sb_q[out_rd[AW-1:0]] == CntMax);
  assign dec_err  = dec_en && !same_reg && (sb_q[WB_o_rd[AW-1:0]] == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_GPR); i++) sb_q[i] <= '0;
    end else begin
      if (inc_en && !same_reg && !inc_err) sb_q[out_rd[AW-1:0]] <= sb_q[out_rd[AW-1:0]] + 1'b1;
      if (dec_en && !same_reg && !dec_err) sb_q[WB_o_rd[AW-1:0]] <= sb_q[WB_o_rd[AW-1:0]] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_GPR); i++) gpr_q[i] <= '0;
    end else if (WB_o_RegWr && idx_ok(WB_o_rd)) begin
      gpr_q[WB_o_rd[AW-1:0]] <= WB_o_rf_busW;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_inst     <= '0;
      out_pre_take <= 1'b0;
      out_rd       <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_wen      <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_inst     <= in_inst;
      out_pre_take <= in_pre_take;
      out_rd       <= dec_rd;
      out_rs1      <= dec_rs1;
      out_rs2      <= dec_rs2;
      out_rs1_data <= rdata1;
      out_rs2_data <= rdata2;
      out_wen      <= dec_wen;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  a_sb_overflow:  assert property (@(posedge clk) disable iff (!rst) !inc_err);
  a_sb_underflow: assert property (@(posedge clk) disable iff (!rst) !dec_err);

endmodule

// File: tb/tb_ysyx_23060136_idu_issue_stage.sv
// Directed bench for the IDU issue stage: decode table plus hazard/cap/flush/backpressure sequences.
module tb_ysyx_23060136_idu_issue_stage;

  logic        clk, rst;
  logic        in_valid, in_ready, in_pre_take, flush;
  logic [63:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid, out_ready, out_pre_take, out_wen;
  logic [63:0] out_pc, out_rs1_data, out_rs2_data;
  logic [31:0] out_inst;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        wb_retire, wb_regwr;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        stall_raw;

  int n_cmp = 0;
  int n_bad = 0;

  ysyx_23060136_idu_issue_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_inst      (in_inst),
    .in_pre_take  (in_pre_take),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .out_pre_take (out_pre_take),
    .out_rd       (out_rd),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_rs1_data (out_rs1_data),
    .out_rs2_data (out_rs2_data),
    .out_wen      (out_wen),
    .WB_o_retire  (wb_retire),
    .WB_o_rd      (wb_rd),
    .WB_o_RegWr   (wb_regwr),
    .WB_o_rf_busW (wb_data),
    .stall_raw    (stall_raw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] d1;
    logic [63:0] d2;
    logic [63:0] wb;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [63:0] pc);
    in_valid = v;
    in_inst  = inst;
    in_pc    = pc;
    #1;
  endtask

  task automatic retire(input logic [4:0] rd, input logic regwr, input logic [63:0] data);
    wb_retire = 1'b1;
    wb_rd     = rd;
    wb_regwr  = regwr;
    wb_data   = data;
    tick();
    wb_retire = 1'b0;
    wb_regwr  = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
  endtask

  task automatic set_vec(input int i, input logic [31:0] inst, input logic wen,
                         input logic [4:0] rd, input logic [63:0] d1, input logic [63:0] d2,
                         input logic [63:0] wb);
    vecs[i].inst = inst;
    vecs[i].pc   = 64'h8000_0000 + 64'(4 * i);
    vecs[i].wen  = wen;
    vecs[i].rd   = rd;
    vecs[i].d1   = d1;
    vecs[i].d2   = d2;
    vecs[i].wb   = wb;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1; in_pre_take = 1'b0;
    in_valid = 1'b0; in_inst = '0; in_pc = '0;
    wb_retire = 1'b0; wb_regwr = 1'b0; wb_rd = '0; wb_data = '0;

    set_vec(0,  enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13), 1'b1, 5'd1, 64'd0, 64'd0, 64'd5);
    set_vec(1,  enc_u(20'hABCDE, 5'd2, 7'h37), 1'b1, 5'd2, 64'd0, 64'd0, 64'hABCD_E000);
    set_vec(2,  enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 1'b1, 5'd3, 64'd5,
            64'hABCD_E000, 64'hABCD_E005);
    set_vec(3,  enc_r(7'h00, 5'd3, 5'd1, 3'd2, 5'd0, 7'h23), 1'b0, 5'd0, 64'd5,
            64'hABCD_E005, 64'd0);
    set_vec(4,  enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h63), 1'b0, 5'd0, 64'd5,
            64'hABCD_E000, 64'd0);
    set_vec(5,  enc_i(12'd1, 5'd1, 3'd0, 5'd0, 7'h13), 1'b0, 5'd0, 64'd5, 64'd5, 64'd0);
    set_vec(6,  enc_i(12'h300, 5'd3, 3'd2, 5'd4, 7'h73), 1'b1, 5'd4, 64'hABCD_E005, 64'd0,
            64'h1800);
    set_vec(7,  32'h0000_0073, 1'b0, 5'd0, 64'd0, 64'd0, 64'd0);
    set_vec(8,  enc_u(20'h0, 5'd5, 7'h6F), 1'b1, 5'd5, 64'd0, 64'd0, 64'h8000_0024);
    set_vec(9,  enc_i(12'd8, 5'd4, 3'd3, 5'd6, 7'h03), 1'b1, 5'd6, 64'h1800, 64'd0, 64'h55);
    set_vec(10, enc_i(12'hFFF, 5'd6, 3'd0, 5'd7, 7'h1B), 1'b1, 5'd7, 64'h55, 64'd0, 64'h54);
    set_vec(11, enc_r(7'h20, 5'd1, 5'd7, 3'd0, 5'd8, 7'h3B), 1'b1, 5'd8, 64'h54, 64'd5,
            64'h4F);
    set_vec(12, 32'h0000_000F, 1'b0, 5'd0, 64'd0, 64'd0, 64'd0);

    // Reset held two cycles with a pending request.
    drive(1'b1, enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13), 64'h100);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_stall", 64'(stall_raw), 64'd0);
      chk("rst_out_pc", out_pc, 64'd0);
      chk("rst_out_rs1_data", out_rs1_data, 64'd0);
    end
    rst = 1'b1;
    drive(1'b0, 32'd0, 64'd0);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Decode table: issue, drain, retire.
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, vecs[i].inst, vecs[i].pc);
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
      chk($sformatf("v%0d_stall", i), 64'(stall_raw), 64'd0);
      tick();
      drive(1'b0, 32'd0, 64'd0);
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_out_pc", i), out_pc, vecs[i].pc);
      chk($sformatf("v%0d_out_wen", i), 64'(out_wen), 64'(vecs[i].wen));
      chk($sformatf("v%0d_out_rd", i), 64'(out_rd), 64'(vecs[i].rd));
      chk($sformatf("v%0d_rs1_data", i), out_rs1_data, vecs[i].d1);
      chk($sformatf("v%0d_rs2_data", i), out_rs2_data, vecs[i].d2);
      tick();
      chk($sformatf("v%0d_drained", i), 64'(out_valid), 64'd0);
      if (vecs[i].wen) retire(vecs[i].rd, 1'b1, vecs[i].wb);
    end

    // Back-to-back independent issue.
    drive(1'b1, enc_i(12'd5, 5'd0, 3'd0, 5'd9, 7'h13), 64'h200);
    chk("b2b_rdy0", 64'(in_ready), 64'd1);
    tick();
    chk("b2b_rd0", 64'(out_rd), 64'd9);
    drive(1'b1, enc_i(12'd7, 5'd0, 3'd0, 5'd10, 7'h13), 64'h204);
    chk("b2b_rdy1", 64'(in_ready), 64'd1);
    chk("b2b_stall1", 64'(stall_raw), 64'd0);
    tick();
    drive(1'b0, 32'd0, 64'd0);
    chk("b2b_valid1", 64'(out_valid), 64'd1);
    chk("b2b_rd1", 64'(out_rd), 64'd10);
    chk("b2b_data1", out_rs1_data, 64'd0);
    tick();
    retire(5'd9, 1'b1, 64'd5);
    retire(5'd10, 1'b1, 64'd7);

    // RAW: add x12,x11,x11 waits for x11 to retire.
    drive(1'b1, enc_i(12'd5, 5'd0, 3'd0, 5'd11, 7'h13), 64'h300);
    tick();
    drive(1'b1, enc_r(7'h00, 5'd11, 5'd11, 3'd0, 5'd12, 7'h33), 64'h304);
    for (int c = 1; c < 4; c++) begin
      chk($sformatf("raw_rdy_c%0d", c), 64'(in_ready), 64'd0);
      chk($sformatf("raw_stall_c%0d", c), 64'(stall_raw), 64'd1);
      tick();
    end
    wb_retire = 1'b1; wb_regwr = 1'b1; wb_rd = 5'd11; wb_data = 64'd5;
    #1;
`ifdef YSYX_23060136_WB_BYPASS_EN
    chk("raw_rdy_retire", 64'(in_ready), 64'd1);
    tick();
    wb_retire = 1'b0; wb_regwr = 1'b0; wb_rd = '0; wb_data = '0;
`else
    chk("raw_rdy_retire", 64'(in_ready), 64'd0);
    chk("raw_stall_retire", 64'(stall_raw), 64'd1);
    tick();
    wb_retire = 1'b0; wb_regwr = 1'b0; wb_rd = '0; wb_data = '0;
    #1;
    chk("raw_rdy_after", 64'(in_ready), 64'd1);
    tick();
`endif
    drive(1'b0, 32'd0, 64'd0);
    chk("raw_valid", 64'(out_valid), 64'd1);
    chk("raw_rd", 64'(out_rd), 64'd12);
    chk("raw_rs1_data", out_rs1_data, 64'd5);
    chk("raw_rs2_data", out_rs2_data, 64'd5);
    tick();
    retire(5'd12, 1'b1, 64'd10);

    // Backpressure: out entry held three cycles.
    out_ready = 1'b0;
    drive(1'b1, enc_i(12'd3, 5'd0, 3'd0, 5'd13, 7'h13), 64'h400);
    tick();
    drive(1'b1, enc_i(12'd4, 5'd0, 3'd0, 5'd14, 7'h13), 64'h404);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp_valid_c%0d", c), 64'(out_valid), 64'd1);
      chk($sformatf("bp_pc_c%0d", c), out_pc, 64'h400);
      chk($sformatf("bp_rd_c%0d", c), 64'(out_rd), 64'd13);
      chk($sformatf("bp_rdy_c%0d", c), 64'(in_ready), 64'd0);
      chk($sformatf("bp_stall_c%0d", c), 64'(stall_raw), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_resume_rdy", 64'(in_ready), 64'd1);
    tick();
    drive(1'b0, 32'd0, 64'd0);
    chk("bp_next_valid", 64'(out_valid), 64'd1);
    chk("bp_next_pc", out_pc, 64'h404);
    tick();
    chk("bp_no_dup", 64'(out_valid), 64'd0);
    retire(5'd13, 1'b1, 64'd3);
    retire(5'd14, 1'b1, 64'd4);

    // In-flight cap on x5.
    drive(1'b1, enc_u(20'h0, 5'd5, 7'h37), 64'h500);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("cap_rdy_c%0d", c), 64'(in_ready), 64'd1);
      tick();
    end
    for (int c = 3; c < 5; c++) begin
      chk($sformatf("cap_rdy_c%0d", c), 64'(in_ready), 64'd0);
      chk($sformatf("cap_stall_c%0d", c), 64'(stall_raw), 64'd1);
      tick();
    end
    wb_retire = 1'b1; wb_rd = 5'd5;
    #1;
    chk("cap_rdy_retire", 64'(in_ready), 64'd0);
    tick();
    wb_retire = 1'b0; wb_rd = '0;
    #1;
    chk("cap_rdy_after", 64'(in_ready), 64'd1);
    tick();
    drive(1'b0, 32'd0, 64'd0);
    chk("cap_4th_valid", 64'(out_valid), 64'd1);
    chk("cap_4th_rd", 64'(out_rd), 64'd5);
    tick();
    for (int c = 0; c < 3; c++) retire(5'd5, 1'b1, 64'd0);

    // Flush drops an x6 writer; the following reader of x6 is not stalled.
    out_ready = 1'b0;
    drive(1'b1, enc_i(12'd9, 5'd0, 3'd0, 5'd6, 7'h13), 64'h600);
    tick();
    chk("fl_valid_pre", 64'(out_valid), 64'd1);
    chk("fl_rd_pre", 64'(out_rd), 64'd6);
    flush = 1'b1;
    drive(1'b1, enc_i(12'd0, 5'd6, 3'd0, 5'd15, 7'h13), 64'h604);
    chk("fl_rdy_during", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_valid_post", 64'(out_valid), 64'd0);
    chk("fl_rdy_post", 64'(in_ready), 64'd1);
    chk("fl_stall_post", 64'(stall_raw), 64'd0);
    tick();
    out_ready = 1'b1;
    drive(1'b0, 32'd0, 64'd0);
    chk("fl_read_valid", 64'(out_valid), 64'd1);
    chk("fl_read_pc", out_pc, 64'h604);
    chk("fl_read_data", out_rs1_data, 64'h55);
    tick();
    retire(5'd15, 1'b1, 64'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
